// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and the default bit period in clock cycles.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      START_BIT = 3'b001,
      DATA_BITS = 3'b010,
      STOP_BITS = 3'b011,
      CLEAN_UP  = 3'b100
   } uart_state_e;

   // 25 MHz / 115200 baud
   localparam int CLKS_PER_BITS_DEF = 217;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops
// preset to 1 so reset never looks like a start bit.
module uart_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling driven by a cycle counter, one-cycle
// valid strobe per good byte and a one-cycle framing-error strobe.
module uart_recv
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BITS = CLKS_PER_BITS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX_serial,
   output logic       RX_DV,
   output logic [7:0] RX_BYTE,
   output logic       RX_Active,
   output logic       RX_Frame_Err
);

   localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BITS / 2 - 1);
   localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BITS - 1);

   logic        rx_s;
   uart_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        dv_q, dv_d;
   logic        err_q, err_d;
   logic        active_q, active_d;

   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (RX_serial),
      .q_o (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         idx_q    <= 3'd0;
         shift_q  <= 8'd0;
         byte_q   <= 8'd0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = dv_q;
      err_d    = err_q;
      active_d = active_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            idx_d = 3'd0;
            if (!rx_s) begin
               state_d  = START_BIT;
               active_d = 1'b1;
            end
         end
         START_BIT: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = 8'd0;
               // A start bit that is gone by mid-bit was a glitch: drop it quietly
               if (!rx_s) begin
                  state_d = DATA_BITS;
               end else begin
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DATA_BITS: begin
            if (cnt_q == BIT_M1) begin
               cnt_d          = 8'd0;
               shift_d[idx_q] = rx_s;
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = STOP_BITS;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         STOP_BITS: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = 8'd0;
               if (rx_s) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               active_d = 1'b0;
               state_d  = CLEAN_UP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         CLEAN_UP: begin
            dv_d    = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = 8'd0;
            idx_d    = 3'd0;
            dv_d     = 1'b0;
            err_d    = 1'b0;
            active_d = 1'b0;
         end
      endcase
   end

   assign RX_DV        = dv_q;
   assign RX_BYTE      = byte_q;
   assign RX_Active    = active_q;
   assign RX_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: table of single frames plus hand-written
// back-to-back, start-glitch and mid-frame reset sequences.
module tb_uart_recv;

   localparam int CPB = 217;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX_serial = 1'b1;
   logic       RX_DV;
   logic [7:0] RX_BYTE;
   logic       RX_Active;
   logic       RX_Frame_Err;

   int vec_cnt = 0;
   int miscmp  = 0;

   uart_recv #(.CLKS_PER_BITS(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .RX_serial    (RX_serial),
      .RX_DV        (RX_DV),
      .RX_BYTE      (RX_BYTE),
      .RX_Active    (RX_Active),
      .RX_Frame_Err (RX_Frame_Err)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling edge
   int         cyc = 0;
   int         dv_count = 0, err_count = 0, both_count = 0, active_cycles = 0;
   int         dv_run = 0, err_run = 0, max_dv_run = 0, max_err_run = 0;
   logic [7:0] dv_bytes[$];
   int         dv_cyc[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (RX_DV) begin
         dv_count++;
         dv_bytes.push_back(RX_BYTE);
         dv_cyc.push_back(cyc);
         dv_run++;
      end else begin
         dv_run = 0;
      end
      if (RX_Frame_Err) begin
         err_count++;
         err_run++;
      end else begin
         err_run = 0;
      end
      if (dv_run > max_dv_run) max_dv_run = dv_run;
      if (err_run > max_err_run) max_err_run = err_run;
      if (RX_DV && RX_Frame_Err) both_count++;
      if (RX_Active) active_cycles++;
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Drive a level for n cycles; inputs change 1 time unit after a rising edge
   task automatic drive_bit(input logic b, input int n);
      RX_serial = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A low stop bit is held for 3/4 of a bit so the line is high again well
   // before the receiver's false-start check after the error
   task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop);
      drive_bit(1'b0, cpb);
      for (int b = 0; b < 8; b++) drive_bit(d[b], cpb);
      if (stop) begin
         drive_bit(1'b1, cpb);
      end else begin
         drive_bit(1'b0, cpb * 3 / 4);
         drive_bit(1'b1, cpb - cpb * 3 / 4);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         cpb;
      logic       stop;
      int         exp_dv;
      int         exp_err;
      logic [7:0] exp_byte;
      int         exp_active;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int dv0, err0, act0, n0;

      vecs[0] = '{8'hA5, 217, 1'b1, 1, 0, 8'hA5, 2061};
      vecs[1] = '{8'h3C, 217, 1'b0, 0, 1, 8'hA5, 0};
      vecs[2] = '{8'h55, 209, 1'b1, 1, 0, 8'h55, 2061};
      vecs[3] = '{8'hC3, 225, 1'b1, 1, 0, 8'hC3, 2061};

      #12;
      check("init_dv", 32'(RX_DV), 32'd0);
      check("init_byte", 32'(RX_BYTE), 32'h00);
      check("init_active", 32'(RX_Active), 32'd0);
      check("init_ferr", 32'(RX_Frame_Err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive_bit(1'b1, 20);

      for (int i = 0; i < 4; i++) begin
         dv0  = dv_count;
         err0 = err_count;
         act0 = active_cycles;
         $display("frame %0h at %0d clk/bit, stop=%0b", vecs[i].data, vecs[i].cpb, vecs[i].stop);
         send_frame(vecs[i].data, vecs[i].cpb, vecs[i].stop);
         drive_bit(1'b1, 3 * CPB);
         check("dv_pulses", 32'(dv_count - dv0), 32'(vecs[i].exp_dv));
         check("ferr_pulses", 32'(err_count - err0), 32'(vecs[i].exp_err));
         check("rx_byte", 32'(RX_BYTE), 32'(vecs[i].exp_byte));
         check("active_after", 32'(RX_Active), 32'd0);
         if (vecs[i].exp_active != 0)
            check("active_cycles", 32'(active_cycles - act0), 32'(vecs[i].exp_active));
      end

      // Back-to-back frames with no idle gap
      dv0  = dv_count;
      err0 = err_count;
      n0   = dv_bytes.size();
      send_frame(8'h00, CPB, 1'b1);
      send_frame(8'hFF, CPB, 1'b1);
      drive_bit(1'b1, 3 * CPB);
      check("b2b_dv_pulses", 32'(dv_count - dv0), 32'd2);
      check("b2b_ferr_pulses", 32'(err_count - err0), 32'd0);
      if (dv_bytes.size() >= n0 + 2) begin
         check("b2b_byte0", 32'(dv_bytes[n0]), 32'h00);
         check("b2b_byte1", 32'(dv_bytes[n0 + 1]), 32'hFF);
         check("b2b_spacing", 32'(dv_cyc[n0 + 1] - dv_cyc[n0]), 32'd2170);
      end

      // Start glitch: 50 cycles low
      dv0  = dv_count;
      err0 = err_count;
      act0 = active_cycles;
      drive_bit(1'b0, 50);
      drive_bit(1'b1, 400);
      check("glitch_dv", 32'(dv_count - dv0), 32'd0);
      check("glitch_ferr", 32'(err_count - err0), 32'd0);
      check("glitch_byte", 32'(RX_BYTE), 32'hFF);
      check("glitch_active_cycles", 32'(active_cycles - act0), 32'd108);
      check("glitch_active_after", 32'(RX_Active), 32'd0);

      // Reset mid-frame, held until the line is back in its stop bit
      dv0  = dv_count;
      err0 = err_count;
      fork
         send_frame(8'h96, CPB, 1'b1);
         begin
            repeat (1000) @(posedge clk);
            check("pre_rst_active", 32'(RX_Active), 32'd1);
            #3 rst = 1'b1;
            #1;
            check("rst_dv", 32'(RX_DV), 32'd0);
            check("rst_byte", 32'(RX_BYTE), 32'h00);
            check("rst_active", 32'(RX_Active), 32'd0);
            check("rst_ferr", 32'(RX_Frame_Err), 32'd0);
            repeat (1100) @(posedge clk);
            #2 rst = 1'b0;
         end
      join
      drive_bit(1'b1, CPB);
      check("rst_frame_dv", 32'(dv_count - dv0), 32'd0);
      check("rst_frame_ferr", 32'(err_count - err0), 32'd0);
      send_frame(8'h5A, CPB, 1'b1);
      drive_bit(1'b1, 3 * CPB);
      check("post_rst_dv", 32'(dv_count - dv0), 32'd1);
      check("post_rst_ferr", 32'(err_count - err0), 32'd0);
      check("post_rst_byte", 32'(RX_BYTE), 32'h5A);

      check("dv_ferr_overlap", 32'(both_count), 32'd0);
      check("dv_width", 32'(max_dv_run), 32'd1);
      check("ferr_width", 32'(max_err_run), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver: the receive-side counterpart of the team's UART transmitter. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from an asynchronous serial line. Bits are sampled at mid-bit using a clock-cycle counter. Each valid byte is presented on a parallel bus with a one-cycle valid strobe; invalid stop bits are flagged as framing errors.

## Interface
- CLKS_PER_BITS, 217, clock cycles per bit (25 MHz / 115200); legal range 4..255.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX_serial  input  1  serial line, asynchronous to clk; idles high.
- RX_DV  output  1  one-cycle pulse: RX_BYTE holds a newly received valid byte.
- RX_BYTE  output  8  last valid received byte; stable between RX_DV pulses.
- RX_Active  output  1  high while a frame is being received.
- RX_Frame_Err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.

## Operation
- RX_serial passes through a 2-flop synchronizer (flops reset to 1) to give rx_s. All decisions use rx_s.
- HALF = CLKS_PER_BITS/2 (integer division, 108 at default). Bit counter is 8 bits wide, bit_index is 3 bits, and the shift register is 8 bits.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BITS, CLEAN_UP. Any undefined encoding goes to IDLE.
- IDLE:
  - Counter and bit_index are held at 0.
  - If rx_s==0: go to START_BIT and set RX_Active=1.
- START_BIT:
  - Count until counter==HALF-1.
  - At that edge, counter is cleared.
  - If rx_s==0: go to DATA_BITS.
  - Else (glitch or false start): go to IDLE, RX_Active=0, no pulses.
- DATA_BITS:
  - Count until counter==CLKS_PER_BITS-1.
  - At that edge: shift[bit_index] <= rx_s and counter is cleared.
  - If bit_index==7: go to STOP_BITS and bit_index is cleared.
  - Else: bit_index increments.
- STOP_BITS:
  - Count until counter==CLKS_PER_BITS-1.
  - At that edge, if rx_s==1: RX_BYTE <= shift and RX_DV <= 1.
  - At that edge, if rx_s==0: RX_Frame_Err <= 1 and RX_BYTE is unchanged.
  - Either way: RX_Active <= 0 and go to CLEAN_UP.
- CLEAN_UP: clear RX_DV and RX_Frame_Err; go to IDLE.
- RX_DV and RX_Frame_Err are never high together.
- There is no backpressure. The consumer must capture RX_BYTE on RX_DV, or before the next RX_DV (at least 10 bit periods later).
- A stuck-low line yields a repeated frame-error pulse every frame period. This is intended (break indication).

## Timing
- Reset values (asynchronous): RX_DV=0, RX_BYTE=8'h00, RX_Active=0, RX_Frame_Err=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Pin-to-rx_s latency: 2 cycles.
- Take the edge at which IDLE sees rx_s==0 as edge 0. Sampling then happens at:
  - start-bit check at edge HALF;
  - data bit k at edge HALF+(k+1)·CLKS_PER_BITS;
  - stop bit at edge HALF+9·CLKS_PER_BITS (2061 at default), where RX_DV/RX_Frame_Err are registered.
- RX_DV / RX_Frame_Err are high for exactly 1 cycle.
- IDLE is re-entered 1 cycle after the stop-bit sample, still mid stop bit. This tolerates back-to-back frames and transmitter clock error of up to about ±4%.
- RX_Active rises the cycle after edge 0 and falls together with RX_DV/RX_Frame_Err.
- Reset mid-frame: the frame is abandoned and no pulse is produced. After release, a low line is treated as a start bit. Any resulting misframe is caught by the stop-bit check.

## Structure
- Package uart_pkg holds:
  - state encoding constants IDLE=3'b000, START_BIT=3'b001, DATA_BITS=3'b010, STOP_BITS=3'b011, CLEAN_UP=3'b100, shared with the transmitter;
  - default CLKS_PER_BITS.
- Sub-module uart_sync: parameterless 2-flop synchronizer with asynchronous preset to 1.

## Test plan
- Reset: assert rst mid-simulation -> all outputs go to their reset values immediately, with no clk edge needed.
- Single byte 8'hA5, driven at exactly CLKS_PER_BITS per bit -> one RX_DV pulse, RX_BYTE=8'hA5, RX_Frame_Err never high, RX_Active high for about 2061 cycles.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two RX_DV pulses 2170 cycles apart, bytes correct and in order.
- Start glitch: RX_serial low for 50 cycles then high -> return to IDLE, no RX_DV, no RX_Frame_Err, RX_BYTE unchanged.
- Framing error: byte 8'h3C with the stop bit driven low -> one RX_Frame_Err pulse, no RX_DV, RX_BYTE keeps its previous value.
- Baud tolerance: frames 8'h55 and 8'hC3 driven at 209 and 225 cycles per bit -> both received correctly; rst asserted mid-frame -> no pulse, and the next clean frame is received correctly.
